// File: rtl/ift_sram_pkg.sv
// Shared types and constants for the taint-tracking SRAM request adapter.
package ift_sram_pkg;

   localparam int unsigned SramWidth    = 64;
   localparam int unsigned RspFifoDepth = 2;

   // One buffered response; the adapter declares the same layout at its own Width.
   typedef struct packed {
      logic                 write;
      logic [SramWidth-1:0] rdata;
      logic [SramWidth-1:0] rdata_taint;
      logic                 ctrl_taint;
   } rsp_entry_t;

endpackage

// File: rtl/ift_rsp_fifo.sv
// Small response FIFO; a push and a pop in the same cycle succeed even when full.
module ift_rsp_fifo
   import ift_sram_pkg::*;
#(
   parameter type         entry_t = rsp_entry_t,
   parameter int unsigned Depth   = RspFifoDepth
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   push_i,
   input  entry_t entry_i,
   input  logic   pop_i,
   output logic   valid_o,
   output entry_t head_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   entry_t            mem_q [Depth];
   entry_t            mem_d [Depth];
   logic [PtrW-1:0]   wptr_q, wptr_d;
   logic [PtrW-1:0]   rptr_q, rptr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              do_push, do_pop;

   assign do_pop  = pop_i & (cnt_q != '0);
   assign do_push = push_i & ((cnt_q != CntW'(Depth)) | do_pop);
   assign valid_o = (cnt_q != '0);
   assign head_o  = valid_o ? mem_q[rptr_q] : '0;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) begin
         mem_d[wptr_q] = entry_i;
         wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (do_pop) begin
         rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
      end
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q  <= '{default: '0};
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/ift_sram_req_adapter.sv
// Valid/ready to single-cycle SRAM adapter with credit-based flow control
// and information-flow taint propagation on every port.
module ift_sram_req_adapter
   import ift_sram_pkg::*;
#(
   parameter  int unsigned Width     = SramWidth,
   parameter  int unsigned Depth     = 256,
   parameter  int unsigned NumTaints = 1,
   localparam int unsigned Aw        = $clog2(Depth),
   localparam int unsigned WB        = Width / 8,
   localparam int unsigned Ob        = $clog2(WB)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   input  logic             req_valid_i_taint,
   output logic             req_ready_o,
   output logic             req_ready_o_taint,
   input  logic             req_write_i,
   input  logic             req_write_i_taint,
   input  logic [63:0]      req_addr_i,
   input  logic [63:0]      req_addr_i_taint,
   input  logic [Width-1:0] req_wdata_i,
   input  logic [Width-1:0] req_wdata_i_taint,
   input  logic [WB-1:0]    req_be_i,
   input  logic [WB-1:0]    req_be_i_taint,
   output logic             rsp_valid_o,
   output logic             rsp_valid_o_taint,
   input  logic             rsp_ready_i,
   input  logic             rsp_ready_i_taint,
   output logic             rsp_write_o,
   output logic             rsp_write_o_taint,
   output logic [Width-1:0] rsp_rdata_o,
   output logic [Width-1:0] rsp_rdata_o_taint,
   output logic             sram_req_o,
   output logic             sram_req_o_taint,
   output logic             sram_write_o,
   output logic             sram_write_o_taint,
   output logic [Aw-1:0]    sram_addr_o,
   output logic [Aw-1:0]    sram_addr_o_taint,
   output logic [Width-1:0] sram_wdata_o,
   output logic [Width-1:0] sram_wdata_o_taint,
   output logic [Width-1:0] sram_wmask_o,
   output logic [Width-1:0] sram_wmask_o_taint,
   input  logic [Width-1:0] sram_rdata_i,
   input  logic [Width-1:0] sram_rdata_i_taint
);

   if (NumTaints != 1) begin : g_num_taints_check
      $error("ift_sram_req_adapter supports NumTaints == 1 only");
   end

   typedef struct packed {
      logic             write;
      logic [Width-1:0] rdata;
      logic [Width-1:0] rdata_taint;
      logic             ctrl_taint;
   } entry_t;

   logic       inflight_q, inflight_d;
   logic       infl_write_q, infl_write_d;
   logic       infl_ctrl_taint_q, infl_ctrl_taint_d;
   logic [1:0] cnt_q, cnt_d;
   logic       cnt_taint_q, cnt_taint_d;
   logic       accept, pop, ctrl_taint, unused_addr;
   entry_t     push_entry, head;

   assign pop         = rsp_valid_o & rsp_ready_i;
   assign req_ready_o = (cnt_q < 2'd2) | pop;
   assign accept      = req_valid_i & req_ready_o;

   assign sram_req_o   = accept;
   assign sram_write_o = req_write_i;
   assign sram_addr_o  = req_addr_i[Ob+Aw-1:Ob];
   assign sram_wdata_o = req_wdata_i;

   assign sram_req_o_taint   = req_valid_i_taint | req_ready_o_taint;
   assign sram_write_o_taint = req_write_i_taint;
   assign sram_addr_o_taint  = req_addr_i_taint[Ob+Aw-1:Ob];
   assign sram_wdata_o_taint = req_wdata_i_taint;

   always_comb begin
      sram_wmask_o       = '0;
      sram_wmask_o_taint = '0;
      for (int i = 0; i < int'(Width); i++) begin
         sram_wmask_o[i]       = req_be_i[i/8];
         sram_wmask_o_taint[i] = req_be_i_taint[i/8];
      end
   end

   // Word-offset and high address bits never reach the SRAM.
   assign unused_addr = ^{req_addr_i[63:Ob+Aw], req_addr_i_taint[63:Ob+Aw],
                          req_addr_i[Ob-1:0], req_addr_i_taint[Ob-1:0]};

   assign ctrl_taint = (|req_addr_i_taint[Ob+Aw-1:Ob]) | req_valid_i_taint | req_write_i_taint;

   always_comb begin
      push_entry.write       = infl_write_q;
      push_entry.ctrl_taint  = infl_ctrl_taint_q;
      push_entry.rdata       = infl_write_q ? '0 : sram_rdata_i;
      push_entry.rdata_taint = {Width{infl_ctrl_taint_q}} |
                               (infl_write_q ? '0 : sram_rdata_i_taint);
   end

   ift_rsp_fifo #(
      .entry_t (entry_t),
      .Depth   (RspFifoDepth)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (inflight_q),
      .entry_i (push_entry),
      .pop_i   (pop),
      .valid_o (rsp_valid_o),
      .head_o  (head)
   );

   assign rsp_write_o       = head.write;
   assign rsp_rdata_o       = head.rdata;
   assign rsp_write_o_taint = head.ctrl_taint;
   assign rsp_rdata_o_taint = head.rdata_taint;
   assign rsp_valid_o_taint = cnt_taint_q | head.ctrl_taint;
   assign req_ready_o_taint = cnt_taint_q;

   always_comb begin
      inflight_d        = accept;
      infl_write_d      = accept & req_write_i;
      infl_ctrl_taint_d = accept & ctrl_taint;
      cnt_d             = cnt_q + {1'b0, accept} - {1'b0, pop};
      cnt_taint_d       = cnt_taint_q;
      // Taint on the credit sticks until every outstanding response drains.
      if ((pop & rsp_ready_i_taint) | (accept & ctrl_taint)) begin
         cnt_taint_d = 1'b1;
      end else if (cnt_d == 2'd0) begin
         cnt_taint_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inflight_q        <= 1'b0;
         infl_write_q      <= 1'b0;
         infl_ctrl_taint_q <= 1'b0;
         cnt_q             <= 2'd0;
         cnt_taint_q       <= 1'b0;
      end else begin
         inflight_q        <= inflight_d;
         infl_write_q      <= infl_write_d;
         infl_ctrl_taint_q <= infl_ctrl_taint_d;
         cnt_q             <= cnt_d;
         cnt_taint_q       <= cnt_taint_d;
      end
   end

endmodule

// File: tb/tb_ift_sram_req_adapter.sv
// Directed self-checking bench for ift_sram_req_adapter (Width=64, Depth=256).
module tb_ift_sram_req_adapter;

   localparam int W  = 64;
   localparam int WB = 8;
   localparam int AW = 8;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          req_valid_i, req_valid_i_taint;
   logic          req_ready_o, req_ready_o_taint;
   logic          req_write_i, req_write_i_taint;
   logic [63:0]   req_addr_i, req_addr_i_taint;
   logic [W-1:0]  req_wdata_i, req_wdata_i_taint;
   logic [WB-1:0] req_be_i, req_be_i_taint;
   logic          rsp_valid_o, rsp_valid_o_taint;
   logic          rsp_ready_i, rsp_ready_i_taint;
   logic          rsp_write_o, rsp_write_o_taint;
   logic [W-1:0]  rsp_rdata_o, rsp_rdata_o_taint;
   logic          sram_req_o, sram_req_o_taint;
   logic          sram_write_o, sram_write_o_taint;
   logic [AW-1:0] sram_addr_o, sram_addr_o_taint;
   logic [W-1:0]  sram_wdata_o, sram_wdata_o_taint;
   logic [W-1:0]  sram_wmask_o, sram_wmask_o_taint;
   logic [W-1:0]  sram_rdata_i, sram_rdata_i_taint;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   ift_sram_req_adapter #(.Width(64), .Depth(256), .NumTaints(1)) dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .req_valid_i        (req_valid_i),
      .req_valid_i_taint  (req_valid_i_taint),
      .req_ready_o        (req_ready_o),
      .req_ready_o_taint  (req_ready_o_taint),
      .req_write_i        (req_write_i),
      .req_write_i_taint  (req_write_i_taint),
      .req_addr_i         (req_addr_i),
      .req_addr_i_taint   (req_addr_i_taint),
      .req_wdata_i        (req_wdata_i),
      .req_wdata_i_taint  (req_wdata_i_taint),
      .req_be_i           (req_be_i),
      .req_be_i_taint     (req_be_i_taint),
      .rsp_valid_o        (rsp_valid_o),
      .rsp_valid_o_taint  (rsp_valid_o_taint),
      .rsp_ready_i        (rsp_ready_i),
      .rsp_ready_i_taint  (rsp_ready_i_taint),
      .rsp_write_o        (rsp_write_o),
      .rsp_write_o_taint  (rsp_write_o_taint),
      .rsp_rdata_o        (rsp_rdata_o),
      .rsp_rdata_o_taint  (rsp_rdata_o_taint),
      .sram_req_o         (sram_req_o),
      .sram_req_o_taint   (sram_req_o_taint),
      .sram_write_o       (sram_write_o),
      .sram_write_o_taint (sram_write_o_taint),
      .sram_addr_o        (sram_addr_o),
      .sram_addr_o_taint  (sram_addr_o_taint),
      .sram_wdata_o       (sram_wdata_o),
      .sram_wdata_o_taint (sram_wdata_o_taint),
      .sram_wmask_o       (sram_wmask_o),
      .sram_wmask_o_taint (sram_wmask_o_taint),
      .sram_rdata_i       (sram_rdata_i),
      .sram_rdata_i_taint (sram_rdata_i_taint)
   );

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic next_cycle();
      @(negedge clk_i);
   endtask

   task automatic idle_inputs();
      req_valid_i = 0; req_valid_i_taint = 0; req_write_i = 0; req_write_i_taint = 0;
      req_addr_i = '0; req_addr_i_taint = '0; req_wdata_i = '0; req_wdata_i_taint = '0;
      req_be_i = '0; req_be_i_taint = '0; rsp_ready_i = 0; rsp_ready_i_taint = 0;
      sram_rdata_i = '0; sram_rdata_i_taint = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_ni = 0;
      next_cycle(); next_cycle(); #1;
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0h exp 1", req_ready_o); end
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0h exp 0", rsp_valid_o); end
      checks++; if (sram_req_o !== 1'b0) begin errors++; $display("FAIL reset_sram_req: got %0h exp 0", sram_req_o); end
      checks++; if ({req_ready_o_taint, rsp_valid_o_taint, rsp_write_o_taint} !== 3'b000) begin
         errors++; $display("FAIL reset_taints: got %0b exp 000", {req_ready_o_taint, rsp_valid_o_taint, rsp_write_o_taint}); end
      checks++; if (rsp_rdata_o !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %0h exp 0", rsp_rdata_o); end
      rst_ni = 1;
      next_cycle();
   endtask

   task automatic test_read();
      rsp_ready_i = 1;
      req_valid_i = 1; req_write_i = 0; req_addr_i = 64'h18; #1;
      checks++; if (sram_req_o !== 1'b1) begin errors++; $display("FAIL read_sram_req: got %0h exp 1", sram_req_o); end
      checks++; if (sram_addr_o !== 8'd3) begin errors++; $display("FAIL read_sram_addr: got %0h exp 3", sram_addr_o); end
      next_cycle();
      req_valid_i = 0; sram_rdata_i = 64'hDEADBEEF; #1;
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL read_latency_n1: got %0h exp 0", rsp_valid_o); end
      next_cycle();
      sram_rdata_i = '0; #1;
      checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL read_rsp_valid_n2: got %0h exp 1", rsp_valid_o); end
      checks++; if (rsp_rdata_o !== 64'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %0h exp deadbeef", rsp_rdata_o); end
      checks++; if (rsp_write_o !== 1'b0) begin errors++; $display("FAIL read_rsp_write: got %0h exp 0", rsp_write_o); end
      next_cycle(); #1;
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL read_drained: got %0h exp 0", rsp_valid_o); end
      idle_inputs();
   endtask

   task automatic test_write();
      rsp_ready_i = 1;
      req_valid_i = 1; req_write_i = 1; req_addr_i = 64'h20; req_be_i = 8'h0F;
      req_wdata_i = 64'h1122334455667788; #1;
      checks++; if (sram_wmask_o !== 64'h00000000FFFFFFFF) begin errors++; $display("FAIL write_wmask: got %0h exp ffffffff", sram_wmask_o); end
      checks++; if (sram_write_o !== 1'b1) begin errors++; $display("FAIL write_sram_write: got %0h exp 1", sram_write_o); end
      checks++; if (sram_wdata_o !== 64'h1122334455667788) begin errors++; $display("FAIL write_wdata: got %0h exp 1122334455667788", sram_wdata_o); end
      checks++; if (sram_addr_o !== 8'd4) begin errors++; $display("FAIL write_addr: got %0h exp 4", sram_addr_o); end
      next_cycle();
      idle_inputs(); rsp_ready_i = 1; sram_rdata_i = 64'hAAAA5555AAAA5555;
      next_cycle(); #1;
      checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL write_rsp_valid: got %0h exp 1", rsp_valid_o); end
      checks++; if (rsp_write_o !== 1'b1) begin errors++; $display("FAIL write_rsp_write: got %0h exp 1", rsp_write_o); end
      checks++; if (rsp_rdata_o !== 64'h0) begin errors++; $display("FAIL write_rdata_zero: got %0h exp 0", rsp_rdata_o); end
      next_cycle();
      idle_inputs();
   endtask

   // Fills the adapter with two reads (addr 0 and 8) while responses are held off.
   task automatic fill_two(input logic [63:0] d0, input logic [63:0] d1);
      rsp_ready_i = 0;
      req_valid_i = 1; req_addr_i = 64'h0; #1;
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready_a: got %0h exp 1", req_ready_o); end
      next_cycle();
      req_addr_i = 64'h8; #1;
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready_b: got %0h exp 1", req_ready_o); end
      next_cycle();
      sram_rdata_i = d0;
      next_cycle();
      req_valid_i = 0;
      sram_rdata_i = d1;
   endtask

   task automatic test_back_to_back();
      rsp_ready_i = 0;
      req_valid_i = 1; req_addr_i = 64'h0; #1;
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_a: got %0h exp 1", req_ready_o); end
      next_cycle();
      req_addr_i = 64'h8; sram_rdata_i = 64'h111; #1;
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_b: got %0h exp 1", req_ready_o); end
      next_cycle();
      req_addr_i = 64'h10; sram_rdata_i = 64'h222; #1;
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %0h exp 0", req_ready_o); end
      checks++; if (sram_req_o !== 1'b0) begin errors++; $display("FAIL b2b_full_no_req: got %0h exp 0", sram_req_o); end
      next_cycle();
      req_valid_i = 0; sram_rdata_i = '0; #1;
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_held_ready: got %0h exp 0", req_ready_o); end
      rsp_ready_i = 1; #1;
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_pop_ready: got %0h exp 1", req_ready_o); end
      checks++; if (rsp_rdata_o !== 64'h111) begin errors++; $display("FAIL b2b_first: got %0h exp 111", rsp_rdata_o); end
      next_cycle(); #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 64'h222) begin
         errors++; $display("FAIL b2b_second: got valid %0h data %0h exp 1 222", rsp_valid_o, rsp_rdata_o); end
      next_cycle(); #1;
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %0h exp 0", rsp_valid_o); end
      idle_inputs();
   endtask

   task automatic test_stream();
      logic [63:0] data [4];
      data[0] = 64'hA0; data[1] = 64'hB1; data[2] = 64'hC2; data[3] = 64'hD3;
      rsp_ready_i = 1;
      for (int c = 0; c < 7; c++) begin
         req_valid_i  = (c < 4);
         req_addr_i   = 64'(c * 8);
         sram_rdata_i = (c >= 1 && c <= 4) ? data[c-1] : 64'h0;
         #1;
         if (c < 4) begin
            checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready c%0d: got %0h exp 1", c, req_ready_o); end
         end
         if (c >= 2 && c < 6) begin
            checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== data[c-2]) begin
               errors++; $display("FAIL stream_rsp c%0d: got valid %0h data %0h exp 1 %0h", c, rsp_valid_o, rsp_rdata_o, data[c-2]); end
         end
         if (c == 6) begin
            checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL stream_empty: got %0h exp 0", rsp_valid_o); end
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_taint();
      rsp_ready_i = 1;
      req_valid_i = 1; req_addr_i = 64'h30; req_addr_i_taint = 64'h10; #1;
      checks++; if (sram_addr_o_taint !== 8'h02) begin errors++; $display("FAIL taint_addr_slice: got %0h exp 02", sram_addr_o_taint); end
      checks++; if (sram_req_o_taint !== 1'b0) begin errors++; $display("FAIL taint_req_clean: got %0h exp 0", sram_req_o_taint); end
      next_cycle();
      idle_inputs(); rsp_ready_i = 1;
      sram_rdata_i = 64'h77; sram_rdata_i_taint = 64'h0F; #1;
      checks++; if (req_ready_o_taint !== 1'b1) begin errors++; $display("FAIL taint_cnt_set: got %0h exp 1", req_ready_o_taint); end
      next_cycle();
      sram_rdata_i = '0; sram_rdata_i_taint = '0; #1;
      checks++; if (rsp_rdata_o_taint !== {64{1'b1}}) begin errors++; $display("FAIL taint_rdata_ones: got %0h exp all ones", rsp_rdata_o_taint); end
      checks++; if ({rsp_valid_o_taint, rsp_write_o_taint} !== 2'b11) begin
         errors++; $display("FAIL taint_head_ctrl: got %0b exp 11", {rsp_valid_o_taint, rsp_write_o_taint}); end
      next_cycle(); #1;
      checks++; if (req_ready_o_taint !== 1'b0) begin errors++; $display("FAIL taint_cnt_clear: got %0h exp 0", req_ready_o_taint); end
      req_valid_i = 1; req_addr_i = 64'h40; #1;
      next_cycle();
      req_valid_i = 0; sram_rdata_i = 64'h99; sram_rdata_i_taint = 64'h00FF00FF;
      next_cycle();
      sram_rdata_i = '0; sram_rdata_i_taint = '0; #1;
      checks++; if (rsp_rdata_o_taint !== 64'h00FF00FF) begin errors++; $display("FAIL taint_clean_rdata: got %0h exp ff00ff", rsp_rdata_o_taint); end
      checks++; if (rsp_valid_o_taint !== 1'b0) begin errors++; $display("FAIL taint_clean_valid: got %0h exp 0", rsp_valid_o_taint); end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_taint_pop();
      fill_two(64'h1, 64'h2);
      next_cycle(); #1;
      checks++; if (req_ready_o_taint !== 1'b0) begin errors++; $display("FAIL tpop_before: got %0h exp 0", req_ready_o_taint); end
      rsp_ready_i = 1; rsp_ready_i_taint = 1; sram_rdata_i = '0;
      next_cycle();
      rsp_ready_i_taint = 0; #1;
      checks++; if (req_ready_o_taint !== 1'b1 || rsp_valid_o !== 1'b1) begin
         errors++; $display("FAIL tpop_sticky: got taint %0h valid %0h exp 1 1", req_ready_o_taint, rsp_valid_o); end
      checks++; if (sram_req_o_taint !== 1'b1) begin errors++; $display("FAIL tpop_sram_req_taint: got %0h exp 1", sram_req_o_taint); end
      next_cycle(); #1;
      checks++; if (req_ready_o_taint !== 1'b0 || rsp_valid_o !== 1'b0) begin
         errors++; $display("FAIL tpop_cleared: got taint %0h valid %0h exp 0 0", req_ready_o_taint, rsp_valid_o); end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      fill_two(64'h333, 64'h444);
      next_cycle(); #1;
      checks++; if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0) begin
         errors++; $display("FAIL rmid_full: got valid %0h ready %0h exp 1 0", rsp_valid_o, req_ready_o); end
      rst_ni = 0; #1;
      checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
         errors++; $display("FAIL rmid_immediate: got valid %0h ready %0h exp 0 1", rsp_valid_o, req_ready_o); end
      next_cycle();
      rst_ni = 1; sram_rdata_i = '0;
      next_cycle(); rsp_ready_i = 1; #1;
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_no_stale: got %0h exp 0", rsp_valid_o); end
      req_valid_i = 1; req_addr_i = 64'h18;
      next_cycle();
      req_valid_i = 0; sram_rdata_i = 64'h5555; #1;
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_idle_latency: got %0h exp 0", rsp_valid_o); end
      next_cycle(); sram_rdata_i = '0; #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 64'h5555) begin
         errors++; $display("FAIL rmid_fresh: got valid %0h data %0h exp 1 5555", rsp_valid_o, rsp_rdata_o); end
      next_cycle(); #1;
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_single: got %0h exp 0", rsp_valid_o); end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_stream();
      test_taint();
      test_taint_pop();
      test_reset_mid();
      next_cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ift_sram_req_adapter.md
IFT_SRAM_REQ_ADAPTER -- requirements
Module: ift_sram_req_adapter

Interface
REQ-001 SHALL have parameter Width, default 64, SRAM word width in bits (multiple of 8).
REQ-002 SHALL have parameter Depth, default 256, SRAM depth in words; Aw=$clog2(Depth), WB=Width/8, Ob=$clog2(WB).
REQ-003 SHALL have parameter NumTaints, default 1; only 1 supported (elaboration assertion).
REQ-004 Ports, in order (name  direction  width  meaning), each data/control port with a same-width *_taint companion, except clk_i and rst_ni:
- clk_i  in  1  clock, rising edge;
- rst_ni  in  1  reset, asynchronous, active-low;
- req_valid_i / req_ready_o  in/out  1  upstream request handshake;
- req_write_i  in  1  1=write, 0=read;
- req_addr_i  in  64  byte address;
- req_wdata_i  in  Width  write data;
- req_be_i  in  WB  byte enables;
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake;
- rsp_write_o  out  1  response belongs to a write;
- rsp_rdata_o  out  Width  read data (0 for writes);
- sram_req_o, sram_write_o  out  1  SRAM request strobes;
- sram_addr_o  out  Aw  word address;
- sram_wdata_o, sram_wmask_o  out  Width  SRAM write data and bit mask;
- sram_rdata_i  in  Width  SRAM read data, valid one cycle after sram_req_o.

Function
REQ-005 Request accepted in cycle N iff req_valid_i & req_ready_o; sram_req_o = that product, combinational, same cycle.
REQ-006 sram_addr_o = req_addr_i[Ob+Aw-1:Ob]; upper and low (sub-word) bits ignored.
REQ-007 sram_wmask_o bit i = req_be_i[i/8]; sram_write_o = req_write_i; sram_wdata_o = req_wdata_i.
REQ-008 One-bit in-flight register set at accept; in cycle N+1 the response entry {write, rdata, taints} is pushed into a 2-entry FIFO; rdata = sram_rdata_i for reads, 0 for writes.
REQ-009 rsp_valid_o = FIFO non-empty; minimum accept-to-rsp_valid latency 2 cycles; responses strictly in order.
REQ-010 Credit counter cnt (0..2) = in-flight + FIFO occupancy; req_ready_o = (cnt<2) | (rsp_valid_o & rsp_ready_i), sustaining one request per cycle under continuous rsp_ready_i.
REQ-011 Simultaneous push and pop on full FIFO SHALL succeed without loss; pop on empty is impossible (rsp_valid_o=0).
REQ-012 Taint: sram_addr_o_taint, sram_wmask_o_taint, sram_wdata_o_taint, sram_write_o_taint are the same slicing/expansion of the input taints; sram_req_o_taint = req_valid_i_taint | req_ready_o_taint.
REQ-013 ctrl_taint of an entry = |addr_taint (used bits) | req_valid_taint | write_taint; entry rdata_taint = sram_rdata_i_taint | {Width{ctrl_taint}} for reads, {Width{ctrl_taint}} for writes.
REQ-014 Sticky cnt_taint SHALL set when a pop occurs with rsp_ready_i_taint=1 or an accept has ctrl_taint=1, and clear only when cnt=0; req_ready_o_taint = cnt_taint; rsp_valid_o_taint = cnt_taint | head ctrl_taint; rsp_write_o_taint = head ctrl_taint.

Reset
REQ-015 While rst_ni=0: FIFO empty, cnt=0, in-flight=0, cnt_taint=0, all outputs and output taints 0 except req_ready_o=1.
REQ-016 Reset mid-operation SHALL drop in-flight and buffered responses; the first accept after release behaves as from idle.

Structure
REQ-017 Package ift_sram_pkg SHALL hold the response-entry struct (write, rdata, rdata_taint, ctrl_taint) and the FIFO depth constant (2).
REQ-018 Sub-module ift_rsp_fifo (2-entry, same clock and reset) SHALL hold the entries; the adapter holds credit, in-flight, and taint logic.

Verification
REQ-019 Read addr 0x18, sram_rdata_i=0xDEADBEEF at N+1, rsp_ready_i=1 -> rsp_valid_o at N+2, rdata 0xDEADBEEF, sram_addr_o=3.
REQ-020 Write be=0x0F, data 0x1122334455667788 -> sram_wmask_o=0x00000000FFFFFFFF, rsp_write_o=1, rdata 0.
REQ-021 Back-to-back reads with rsp_ready_i=0 -> two accepts, then req_ready_o=0; raise rsp_ready_i -> one response per cycle in order.
REQ-022 Read with addr_taint bit 4 set -> rsp_rdata_o_taint all-ones; untainted read -> equals sram_rdata_i_taint.
REQ-023 rsp_ready_i_taint=1 during a pop -> req_ready_o_taint=1 until cnt=0, then 0.
REQ-024 Assert rst_ni=0 with 2 entries buffered -> rsp_valid_o=0 and req_ready_o=1 immediately, no stale response after release.
